// File: rtl/core_launch_ctrl.sv
// Host-side launcher: sends one PC-write packet to start the core, watches its state, and returns one status record per job.
// Optional watchdog timeout is enabled by defining CORE_LAUNCH_CTRL_WATCHDOG_EN.
package core_launch_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_e;
endpackage

module core_launch_ctrl
    import core_launch_ctrl_pkg::*;
#(
    parameter int imem_addr_width_p = 10,
    parameter int cycle_cnt_width_p = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         job_valid_i,
    input  logic [imem_addr_width_p-1:0] job_pc_i,
    input  logic [cycle_cnt_width_p-1:0] job_limit_i,
    output logic                         job_ready_o,
    output logic                         net_valid_o,
    output logic [2:0]                   net_op_o,
    output logic [imem_addr_width_p-1:0] net_addr_o,
    input  logic                         net_ready_i,
    input  state_e                       core_state_i,
    output logic                         resp_valid_o,
    output logic [1:0]                   resp_status_o,
    output logic [cycle_cnt_width_p-1:0] resp_cycles_o,
    input  logic                         resp_ready_i
);

    localparam logic [2:0] OP_PC_WRITE = 3'b001;
    localparam logic [1:0] ST_DONE     = 2'b00;
    localparam logic [1:0] ST_ERR      = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;
    localparam logic [cycle_cnt_width_p-1:0] CNT_ZERO = {cycle_cnt_width_p{1'b0}};
    localparam logic [cycle_cnt_width_p-1:0] CNT_ONE  = {{(cycle_cnt_width_p-1){1'b0}}, 1'b1};
    localparam logic [imem_addr_width_p-1:0] PC_ZERO  = {imem_addr_width_p{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND   = 3'd1,
        S_ARM    = 3'd2,
        S_WATCH  = 3'd3,
        S_REPORT = 3'd4
    } fsm_e;

    fsm_e                         fsm_r, fsm_nxt_s;
    logic [imem_addr_width_p-1:0] pc_r;
    logic [cycle_cnt_width_p-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [cycle_cnt_width_p-1:0] cycles_r, cycles_nxt_s;
    logic [1:0]                   status_r, status_nxt_s;
    logic                         accept_s;
    logic                         core_idle_s, core_run_s, core_err_s;
    logic                         limit_hit_s;

    // Undefined core state encodings are treated as ERR.
    assign core_idle_s = (core_state_i == IDLE);
    assign core_run_s  = (core_state_i == RUN);
    assign core_err_s  = !core_idle_s && !core_run_s;
    assign accept_s    = job_valid_i && job_ready_o;
    assign cnt_inc_s   = (&cnt_r) ? cnt_r : (cnt_r + CNT_ONE);

`ifdef CORE_LAUNCH_CTRL_WATCHDOG_EN
    logic [cycle_cnt_width_p-1:0] limit_r;

    // Watchdog limit latched at job accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            limit_r <= CNT_ZERO;
        end else if (accept_s) begin
            limit_r <= job_limit_i;
        end
    end

    assign limit_hit_s = (limit_r != CNT_ZERO) && (cnt_r == limit_r);
`else
    logic unused_limit_s;
    assign unused_limit_s = ^job_limit_i;
    assign limit_hit_s    = 1'b0;
`endif

    // State register plus latched PC, counter and response fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_r    <= S_IDLE;
            pc_r     <= PC_ZERO;
            cnt_r    <= CNT_ZERO;
            status_r <= ST_DONE;
            cycles_r <= CNT_ZERO;
        end else begin
            fsm_r    <= fsm_nxt_s;
            cnt_r    <= cnt_nxt_s;
            status_r <= status_nxt_s;
            cycles_r <= cycles_nxt_s;
            if (accept_s) begin
                pc_r <= job_pc_i;
            end
        end
    end

    // Next-state logic. In S_ARM the counter times the wait for RUN; on the
    // RUN sample it restarts at 1 so it counts the core's RUN cycles from then on.
    always_comb begin
        fsm_nxt_s    = fsm_r;
        cnt_nxt_s    = cnt_r;
        status_nxt_s = status_r;
        cycles_nxt_s = cycles_r;
        case (fsm_r)
            S_IDLE: begin
                if (accept_s) begin
                    fsm_nxt_s = S_SEND;
                    cnt_nxt_s = CNT_ZERO;
                end else begin
                    fsm_nxt_s = S_IDLE;
                end
            end
            S_SEND: begin
                if (net_ready_i) begin
                    fsm_nxt_s = S_ARM;
                end else begin
                    fsm_nxt_s = S_SEND;
                end
            end
            S_ARM: begin
                if (core_err_s) begin
                    fsm_nxt_s    = S_REPORT;
                    status_nxt_s = ST_ERR;
                    cycles_nxt_s = CNT_ZERO;
                end else if (core_run_s) begin
                    fsm_nxt_s = S_WATCH;
                    cnt_nxt_s = CNT_ONE;
                end else if (limit_hit_s) begin
                    fsm_nxt_s    = S_REPORT;
                    status_nxt_s = ST_TIMEOUT;
                    cycles_nxt_s = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            S_WATCH: begin
                if (core_err_s) begin
                    fsm_nxt_s    = S_REPORT;
                    status_nxt_s = ST_ERR;
                    cycles_nxt_s = cnt_r;
                end else if (core_idle_s) begin
                    fsm_nxt_s    = S_REPORT;
                    status_nxt_s = ST_DONE;
                    cycles_nxt_s = cnt_r;
                end else if (limit_hit_s) begin
                    fsm_nxt_s    = S_REPORT;
                    status_nxt_s = ST_TIMEOUT;
                    cycles_nxt_s = cnt_r;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            S_REPORT: begin
                if (resp_ready_i) begin
                    fsm_nxt_s = S_IDLE;
                end else begin
                    fsm_nxt_s = S_REPORT;
                end
            end
            default: begin
                fsm_nxt_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the state register; payloads are zero when not valid.
    always_comb begin
        job_ready_o   = 1'b0;
        net_valid_o   = 1'b0;
        net_op_o      = 3'b000;
        net_addr_o    = PC_ZERO;
        resp_valid_o  = 1'b0;
        resp_status_o = 2'b00;
        resp_cycles_o = CNT_ZERO;
        case (fsm_r)
            S_IDLE: begin
                job_ready_o = !reset;
            end
            S_SEND: begin
                net_valid_o = 1'b1;
                net_op_o    = OP_PC_WRITE;
                net_addr_o  = pc_r;
            end
            S_REPORT: begin
                resp_valid_o  = 1'b1;
                resp_status_o = status_r;
                resp_cycles_o = cycles_r;
            end
            default: begin
                job_ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/core_launch_ctrl.md
# core_launch_ctrl

Host-side initiator for the core's network start protocol. It accepts a launch job (start PC, watchdog limit) and issues one PC-write command packet on the core's network port, which moves the core state machine from IDLE to RUN. It then tracks the core's reported state until the core returns to IDLE (`WAIT` retired), enters ERR, or the watchdog expires, and returns one status record per job. It sits between the test/host job queue and the core network input.

## Interface
Parameters:
- `imem_addr_width_p`, 10, PC / instruction-memory address width
- `cycle_cnt_width_p`, 16, width of run-cycle counter and watchdog limit

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `job_valid_i` in 1: job offered
- `job_pc_i` in `imem_addr_width_p`: start PC
- `job_limit_i` in `cycle_cnt_width_p`: watchdog limit in cycles, 0 = no limit
- `job_ready_o` out 1: job accepted when `job_valid_i & job_ready_o`
- `net_valid_o` out 1: command packet valid
- `net_op_o` out 3: command opcode, `3'b001` = PC write, others never driven
- `net_addr_o` out `imem_addr_width_p`: PC payload
- `net_ready_i` in 1: network accepts packet
- `core_state_i` in `state_e`: core state (IDLE/RUN/ERR)
- `resp_valid_o` out 1: status record valid
- `resp_status_o` out 2: `00` DONE, `01` ERR, `10` TIMEOUT
- `resp_cycles_o` out `cycle_cnt_width_p`: cycles observed in RUN, saturating
- `resp_ready_i` in 1: status consumed

## Operation
- FSM states: S_IDLE, S_SEND, S_ARM, S_WATCH, S_REPORT. Reset → S_IDLE.
- S_IDLE: `job_ready_o`=1. On accept, latch PC and limit, clear counter → S_SEND.
- S_SEND: `net_valid_o`=1, `net_op_o`=`3'b001`, `net_addr_o`=latched PC. All three stay stable until `net_ready_i`. On handshake → S_ARM.
- S_ARM: wait for the core to leave IDLE. `core_state_i`==RUN → S_WATCH. `core_state_i`==ERR → S_REPORT with ERR. The counter also runs here against the limit, so a core that never starts gives TIMEOUT.
- S_WATCH: counter increments each cycle with RUN sampled, saturating at all-ones. `core_state_i`==IDLE → DONE. ERR → ERR. Counter == limit (limit≠0) → TIMEOUT.
- Priority when events coincide in one cycle: ERR > DONE > TIMEOUT.
- S_REPORT: `resp_valid_o`=1. Status and cycles stay stable until `resp_ready_i`, then → S_IDLE.
- ERR is sticky in the core, and this block does not reset the core. After an ERR report, later jobs report ERR from S_ARM.
- Core state values outside IDLE/RUN/ERR are treated as ERR.

## Timing
- Reset values: `job_ready_o`=0 during the reset cycle and 1 in the first cycle after it. All other outputs 0, counter 0.
- Job accept to `net_valid_o`: 1 cycle.
- Network handshake to first `core_state_i` sample in S_ARM: 1 cycle.
- Terminal core state sampled in cycle N → `resp_valid_o` in cycle N+1.
- Response handshake → `job_ready_o`=1 in the next cycle. No job is accepted in the same cycle as a response handshake.
- `resp_cycles_o` counts RUN cycles seen in S_WATCH, excluding the terminating cycle.
- `reset` asserted in any state aborts the job silently: no response, outputs cleared next edge.

## Configuration
- `CORE_LAUNCH_CTRL_WATCHDOG_EN` defined: limit compare active, and status TIMEOUT is possible.
- Not defined: `job_limit_i` is ignored, TIMEOUT is never produced, and the FSM waits indefinitely in S_ARM / S_WATCH. The counter still saturates.

## Test plan
- Reset with all inputs 0, release → `job_ready_o`=1 in the first post-reset cycle, all other outputs 0.
- Job PC=`10'h040`, limit 0; `net_ready_i` held low 3 cycles; core RUN for 25 cycles then IDLE → packet held stable for 4 cycles with op `001`, addr `040`; response DONE, cycles=25.
- Job limit 8, core stays RUN → TIMEOUT with cycles=8, exactly 1 cycle after the counter reaches 8. With the macro undefined, no response ever appears.
- Core goes RUN, then ERR on the same cycle the counter hits the limit → ERR (priority check). A following job reports ERR from S_ARM.
- `resp_ready_i` low 5 cycles → status and cycles stable, then `job_ready_o`=1 one cycle after the handshake. Reset asserted mid-S_WATCH → no response, returns to S_IDLE.
- Core stays IDLE after the packet is sent, limit 4 → TIMEOUT with cycles=0.
